// File: rtl/outport_tx.sv
// rtl/outport_tx.sv - out-port register plus FIFO feeding an external device over valid/ready
module outport_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int PTR_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  outport_enable,
  input  logic [DATA_WIDTH-1:0] bus_Data,
  output logic [DATA_WIDTH-1:0] outport_Data,
  output logic [DATA_WIDTH-1:0] dev_data,
  output logic                  dev_valid,
  input  logic                  dev_ready,
  output logic                  out_full,
  output logic [PTR_WIDTH:0]    out_count,
  output logic                  overflow
);

  localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr_next;
  logic [PTR_WIDTH:0]    count_next;
  logic [DATA_WIDTH-1:0] head_next;
  logic                  pop;
  logic                  push;

  assign out_full = (out_count == FULL_COUNT);

  // Handshake decode and next-state of the queue; the head register is
  // fed from the incoming bus word when that word becomes the oldest entry.
  always_comb begin
    pop         = dev_valid & dev_ready;
    push        = outport_enable & (~out_full | pop);
    rd_ptr_next = pop ? rd_ptr + 1'b1 : rd_ptr;
    count_next  = out_count;
    if (push && !pop) begin
      count_next = out_count + 1'b1;
    end else if (pop && !push) begin
      count_next = out_count - 1'b1;
    end
    head_next = dev_data;
    if (count_next != '0) begin
      if (push && (wr_ptr == rd_ptr_next)) begin
        head_next = bus_Data;
      end else begin
        head_next = mem[rd_ptr_next];
      end
    end
  end

  // Storage array; contents need no reset because only written slots are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus_Data;
    end
  end

  // Pointers, count, registered device outputs, out-port register and sticky overflow.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      out_count    <= '0;
      dev_valid    <= 1'b0;
      dev_data     <= '0;
      outport_Data <= '0;
      overflow     <= 1'b0;
    end else begin
      rd_ptr    <= rd_ptr_next;
      out_count <= count_next;
      dev_valid <= (count_next != '0);
      dev_data  <= head_next;
      if (push) begin
        wr_ptr       <= wr_ptr + 1'b1;
        outport_Data <= bus_Data;
      end else if (outport_enable) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_outport_tx.sv
// tb/tb_outport_tx.sv - randomized and directed self-checking bench for outport_tx
module tb_outport_tx;

  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          clr_n = 1'b0;
  logic          outport_enable = 1'b0;
  logic [DW-1:0] bus_Data = '0;
  logic [DW-1:0] outport_Data;
  logic [DW-1:0] dev_data;
  logic          dev_valid;
  logic          dev_ready = 1'b0;
  logic          out_full;
  logic [2:0]    out_count;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_port = '0;
  logic          m_ovf = 1'b0;
  logic [DW-1:0] rx[$];

  outport_tx #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_WIDTH(2)) dut (
    .clk            (clk),
    .clr_n          (clr_n),
    .outport_enable (outport_enable),
    .bus_Data       (bus_Data),
    .outport_Data   (outport_Data),
    .dev_data       (dev_data),
    .dev_valid      (dev_valid),
    .dev_ready      (dev_ready),
    .out_full       (out_full),
    .out_count      (out_count),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 64'(dev_valid), 64'(m_q.size() != 0));
    check({tag, ".count"}, 64'(out_count), 64'(m_q.size()));
    check({tag, ".full"}, 64'(out_full), 64'(m_q.size() == DEPTH));
    check({tag, ".port"}, 64'(outport_Data), 64'(m_port));
    check({tag, ".ovf"}, 64'(overflow), 64'(m_ovf));
    if (m_q.size() != 0) check({tag, ".data"}, 64'(dev_data), 64'(m_q[0]));
  endtask

  // One clock cycle: drive, let the edge happen, advance the model, compare.
  task automatic cycle(input logic en, input logic [DW-1:0] d, input logic rdy, input string tag);
    bit do_pop;
    bit do_push;
    outport_enable = en;
    bus_Data = d;
    dev_ready = rdy;
    do_pop = (m_q.size() != 0) && rdy;
    do_push = en && ((m_q.size() < DEPTH) || do_pop);
    if (dev_valid && rdy) rx.push_back(dev_data);
    @(posedge clk);
    #1;
    if (do_pop) void'(m_q.pop_front());
    if (do_push) begin
      m_q.push_back(d);
      m_port = d;
    end else if (en) begin
      m_ovf = 1'b1;
    end
    outport_enable = 1'b0;
    dev_ready = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    clr_n = 1'b0;
    #2;
    check({tag, ".port0"}, 64'(outport_Data), 64'h0);
    check({tag, ".data0"}, 64'(dev_data), 64'h0);
    check({tag, ".valid0"}, 64'(dev_valid), 64'h0);
    check({tag, ".count0"}, 64'(out_count), 64'h0);
    check({tag, ".full0"}, 64'(out_full), 64'h0);
    check({tag, ".ovf0"}, 64'(overflow), 64'h0);
    m_q.delete();
    m_port = '0;
    m_ovf = 1'b0;
    clr_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] held;
    logic [DW-1:0] fill[4];
    int written;
    int budget;
    fill[0] = 32'h11; fill[1] = 32'h22; fill[2] = 32'h33; fill[3] = 32'h44;

    @(posedge clk);
    #1;
    do_reset("rst");

    // single word, then one pop
    cycle(1'b1, 32'hA5, 1'b0, "a5_write");
    cycle(1'b0, 32'h0, 1'b1, "a5_pop");

    // fill, reject fifth write, drain in order
    for (int i = 0; i < 4; i++) cycle(1'b1, fill[i], 1'b0, "fill");
    cycle(1'b1, 32'h55, 1'b0, "reject");
    check("reject.port44", 64'(outport_Data), 64'h44);
    check("reject.ovf1", 64'(overflow), 64'h1);
    rx.delete();
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, "drain");
    check("drain.n", 64'(rx.size()), 64'd4);
    for (int i = 0; i < rx.size() && i < 4; i++) check("drain.order", 64'(rx[i]), 64'(fill[i]));

    // full with simultaneous pop and write
    do_reset("rst2");
    for (int i = 0; i < 4; i++) cycle(1'b1, fill[i], 1'b0, "fill2");
    rx.delete();
    cycle(1'b1, 32'h66, 1'b1, "fullpp");
    check("fullpp.popped", 64'(rx.size() == 1 ? rx[0] : 32'hFFFF_FFFF), 64'h11);
    check("fullpp.cnt4", 64'(out_count), 64'd4);
    check("fullpp.ovf0", 64'(overflow), 64'h0);
    check("fullpp.port66", 64'(outport_Data), 64'h66);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, "drain2");

    // wrap-around with toggling ready; producer stalls only when it would be rejected
    rx.delete();
    written = 0;
    budget = 0;
    while ((written < 10 || m_q.size() != 0) && budget < 100) begin
      logic rdy;
      logic en;
      rdy = (budget % 2) == 0;
      en = (written < 10) && !(out_full && !rdy);
      cycle(en, 32'h100 + DW'(written), rdy, "wrap");
      if (en) written++;
      budget++;
    end
    check("wrap.timeout", 64'(budget < 100), 64'h1);
    check("wrap.n", 64'(rx.size()), 64'd10);
    for (int i = 0; i < rx.size() && i < 10; i++) check("wrap.seq", 64'(rx[i]), 64'(32'h100 + i));

    // backpressure: hold ready low for 5 cycles, then exactly one pop
    cycle(1'b1, 32'hAB, 1'b0, "bp_a");
    cycle(1'b1, 32'hCD, 1'b0, "bp_b");
    held = dev_data;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 32'h0, 1'b0, "bp_hold");
      check("bp.stable_data", 64'(dev_data), 64'(held));
      check("bp.stable_valid", 64'(dev_valid), 64'h1);
    end
    cycle(1'b0, 32'h0, 1'b1, "bp_release");
    check("bp.one_pop", 64'(out_count), 64'd1);
    cycle(1'b0, 32'h0, 1'b1, "bp_empty");

    // reset mid-operation with three words queued
    for (int i = 0; i < 3; i++) cycle(1'b1, fill[i], 1'b0, "pre_rst");
    check("pre_rst.cnt3", 64'(out_count), 64'd3);
    do_reset("rst3");
    @(posedge clk);
    #1;
    check_all("post_rst_idle");
    rx.delete();
    cycle(1'b1, 32'hDEADBEEF, 1'b0, "dead_write");
    check("dead.data", 64'(dev_data), 64'hDEADBEEF);
    cycle(1'b0, 32'h0, 1'b1, "dead_pop");
    cycle(1'b0, 32'h0, 1'b1, "dead_idle");
    check("dead.only", 64'(rx.size()), 64'd1);
    check("dead.first", 64'(rx.size() != 0 ? rx[0] : 32'h0), 64'hDEADBEEF);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0 ? 1 : 0) & 1'(i % 7 != 0),
            "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
